// File: rtl/hex_digit_scanner.sv
// Multiplexed hex display scanner: refresh prescaler, per-slot blank guard,
// frame-coherent value capture and leading-zero blanking feeding a 7-seg decoder.
module hex_digit_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] Value_in,
  input  logic [NUM_DIGITS-1:0]   Dp_in,
  input  logic                    Blank_lz_in,
  input  logic                    Enable_in,
  output logic [3:0]              Hex_out,
  output logic [NUM_DIGITS-1:0]   Digit_sel_out,
  output logic                    Dp_out,
  output logic                    Frame_done_out
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GUARD = 2'd1;
  localparam logic [1:0] S_DRIVE = 2'd2;

  localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [1:0]                  state;
  logic [CW-1:0]               cnt;
  logic [IW-1:0]               idx;
  logic [NUM_DIGITS-1:0][3:0]  shadow;
  logic [NUM_DIGITS-1:0]       shadow_dp;
  logic                        first;
  logic [NUM_DIGITS-1:0]       blank;
  logic                        wrap;
  logic                        drive;

  // A digit blanks when it and every more significant nibble are zero.
  always_comb begin
    logic zero_above;
    blank      = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above && (shadow[i] == 4'h0);
      blank[i]   = Blank_lz_in && zero_above;
    end
  end

  assign wrap  = Enable_in && (state == S_DRIVE) && (cnt == CNT_LAST) && (idx == IDX_LAST);
  assign drive = Enable_in && (state == S_DRIVE) && !blank[idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_GUARD;
      cnt            <= '0;
      idx            <= '0;
      shadow         <= '0;
      shadow_dp      <= '0;
      first          <= 1'b1;
      Hex_out        <= 4'h0;
      Digit_sel_out  <= '1;
      Dp_out         <= 1'b1;
      Frame_done_out <= 1'b0;
    end else begin
      first <= 1'b0;
      if (first || wrap) begin
        shadow    <= Value_in;
        shadow_dp <= Dp_in;
      end
      Frame_done_out <= wrap;

      if (!Enable_in) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            state <= S_GUARD;
            cnt   <= '0;
          end
          S_GUARD: begin
            cnt <= cnt + CW'(1);
            if (cnt == GUARD_LAST) state <= S_DRIVE;
          end
          S_DRIVE: begin
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              state <= S_GUARD;
              idx   <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            state <= S_GUARD;
            cnt   <= '0;
          end
        endcase
      end

      // Outputs are blanked on the very edge enable drops, not one slot later.
      Hex_out       <= shadow[idx];
      Digit_sel_out <= drive ? ~(NUM_DIGITS'(1) << idx) : '1;
      Dp_out        <= drive ? ~shadow_dp[idx] : 1'b1;
    end
  end

endmodule
